alu4_seq: RTL
=============

# alu4_seq

Sequencer and 4-entry register file that drives the combinational `alu4` (ports r, of, a, b, cin, m) and captures its result. It accepts one command per valid/ready handshake, either an immediate load or an ALU operation on two registers. For an ALU operation it presents registered operands and mode to `alu4` for one cycle, writes the result back to the register file, and returns result and overflow on a valid/ready response channel.

## Interface
- No parameters: data width 4, register count 4, mode width 3 are fixed by `alu4`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command; high only in IDLE.
- `cmd_ld` input 1: 1 = load `cmd_imm` into `cmd_dst`; 0 = ALU operation.
- `cmd_op` input 3: `alu4` mode: 000 add, 001 sub, 010 compare, 011 and, 100 or, 101 complement, 110 increment, 111 decrement.
- `cmd_cin` input 1: carry-in passed to `alu4`.
- `cmd_srca` / `cmd_srcb` input 2 each: source register indices.
- `cmd_dst` input 2: destination register index.
- `cmd_imm` input 4: load data.
- `alu_a` / `alu_b` output 4 each: operands to `alu4`.
- `alu_m` output 3 and `alu_cin` output 1: mode and carry-in to `alu4`.
- `alu_r` input 4 and `alu_of` input 1: result and overflow from `alu4`.
- `res_valid` output 1: response present.
- `res_ready` input 1: response consumer ready.
- `res_data` output 4: result, or load data.
- `res_of` output 1: captured overflow, 0 for loads.
- `of_sticky` output 1: see Configuration.
- `rd_addr` input 2 and `rd_data` output 4: combinational debug read of the register file.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - ISSUE: drive `alu4`.
  - RESP: `res_valid`=1.
- Handshake at IDLE:
  - When `cmd_valid & cmd_ready`, all command fields are latched.
  - If `cmd_ld`=1: `regs[dst]`←`imm`, `res_data`←`imm`, `res_of`←0, next state RESP.
  - Otherwise: `alu_a`←`regs[srca]`, `alu_b`←`regs[srcb]`, `alu_m`←`op`, `alu_cin`←`cin`, next state ISSUE.
- ISSUE is one cycle. At its closing edge: `res_data`←`alu_r`, `res_of`←`alu_of`, `regs[dst]`←`alu_r`, next state RESP.
- The compare op writes back like every other op; the result encoding is whatever `alu4` defines.
- RESP holds `res_data`/`res_of` stable until `res_valid & res_ready`, then moves to IDLE. `res_valid` is never dropped before it is accepted.
- `srca`=`srcb` is legal. `dst` equal to a source is legal: sources are read at the accept edge and the old value is used.
- `alu_a`/`alu_b`/`alu_m`/`alu_cin` hold their last values outside ISSUE. `alu4` outputs are ignored outside ISSUE.
- All arithmetic is done inside `alu4`. This block does no width extension and no wrap handling; results are 4 bits exactly as returned.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State goes to IDLE.
  - All regs become 0.
  - `alu_a`/`alu_b`/`alu_m`/`alu_cin`, `res_data`, `res_of`, `of_sticky` become 0 and `res_valid` becomes 0.
  - `cmd_ready` follows state (IDLE), but commands are ignored while `rst_n`=0.
- ALU command accepted at edge k: ISSUE during cycle k..k+1, `res_valid`=1 from edge k+2. Minimum 3 cycles per ALU command.
- Load accepted at edge k: `res_valid`=1 from edge k+1. Minimum 2 cycles per load.
- When `res_ready` is already high in RESP, IDLE is re-entered next edge. Back-to-back commands are accepted no sooner than that.
- `cmd_ready`, `res_valid` are decoded from state only, with no combinational path from `cmd_valid` or `res_ready`.
- Reset mid-operation (ISSUE or RESP): the in-flight result is discarded and the register write in ISSUE does not occur.
- `rd_data` reflects writes the cycle after the write edge.

## Configuration
- `ALU4_SEQ_STICKY_OF_EN` defined:
  - `of_sticky` is set when an ALU op captures `alu_of`=1.
  - It is cleared only by reset or by a load with `cmd_imm`=4'b0000 to `cmd_dst`=2'b00.
  - When both happen at once, clear wins.
- Not defined: `of_sticky` is tied to 0 and no flop is inferred.

## Test plan
- Reset then idle: all outputs 0 except `cmd_ready`=1; `rd_data`=0 for all four addresses.
- Load r0=4'b1111, r1=4'b0001, then add r2=r0+r1 with `cin`=0:
  - `alu_a`=1111, `alu_b`=0001, `alu_m`=000 during ISSUE.
  - `res_data`=0000 and `res_of` equals `alu_of` sampled in ISSUE.
  - `rd_data`(r2)=0000.
- Load r0=4'b1010, r1=4'b0101; run and (011), or (100), sub (001) into r3 each time: `res_data` = 0000, 1111, and the `alu4` sub result respectively; each response arrives exactly 2 edges after accept.
- Hold `res_ready`=0 for 5 cycles in RESP: `res_valid` and `res_data` are stable, `cmd_ready`=0, and a `cmd_valid` pulse is not accepted.
- Command with `dst`=`srca`=r1 doing increment (110) on r1=0111: `alu_a`=0111, then r1 becomes the `alu4` increment result.
- Assert `rst_n`=0 during ISSUE of a write to r2=4'b0110: after release r2=0, `res_valid`=0.
- With `ALU4_SEQ_STICKY_OF_EN`: an overflowing add sets `of_sticky`=1, which holds through later ops and clears after the r0←0000 load.

Source files
------------

// File: rtl/alu4_seq.sv
// Command sequencer and 4x4-bit register file wrapped around the external alu4.
// Optional sticky overflow flag: define ALU4_SEQ_STICKY_OF_EN.
module alu4_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_ld,
    input  logic [2:0] cmd_op,
    input  logic       cmd_cin,
    input  logic [1:0] cmd_srca,
    input  logic [1:0] cmd_srcb,
    input  logic [1:0] cmd_dst,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_m,
    output logic       alu_cin,
    input  logic [3:0] alu_r,
    input  logic       alu_of,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_of,
    output logic       of_sticky,
    input  logic [1:0] rd_addr,
    output logic [3:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state_reg;
    logic [1:0] dst_reg;
    logic [3:0] regs [4];

    // Handshake flags come from state alone so no input reaches them combinationally.
    assign cmd_ready = (state_reg == IDLE);
    assign res_valid = (state_reg == RESP);
    assign rd_data   = regs[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dst_reg   <= 2'd0;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            alu_m     <= 3'd0;
            alu_cin   <= 1'b0;
            res_data  <= 4'd0;
            res_of    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 4'd0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        dst_reg <= cmd_dst;
                        if (cmd_ld) begin
                            regs[cmd_dst] <= cmd_imm;
                            res_data      <= cmd_imm;
                            res_of        <= 1'b0;
                            state_reg     <= RESP;
                        end else begin
                            // Sources are sampled here, so dst==src sees the old value.
                            alu_a     <= regs[cmd_srca];
                            alu_b     <= regs[cmd_srcb];
                            alu_m     <= cmd_op;
                            alu_cin   <= cmd_cin;
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    res_data      <= alu_r;
                    res_of        <= alu_of;
                    regs[dst_reg] <= alu_r;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ALU4_SEQ_STICKY_OF_EN
    logic of_sticky_reg;

    // The r0<-0000 load clear is tested first so it wins over a simultaneous set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_sticky_reg <= 1'b0;
        end else if (state_reg == IDLE && cmd_valid && cmd_ld &&
                     cmd_imm == 4'b0000 && cmd_dst == 2'b00) begin
            of_sticky_reg <= 1'b0;
        end else if (state_reg == ISSUE && alu_of) begin
            of_sticky_reg <= 1'b1;
        end
    end

    assign of_sticky = of_sticky_reg;
`else
    assign of_sticky = 1'b0;
`endif

endmodule
